// File: rtl/spi_subperipheral_router_if.sv
// spi_subperipheral_router_if: front-end address/data bus plus per-channel data lanes; slave = router side, master = front-end/driver side
interface spi_subperipheral_router_if #(
  parameter int NUM_SUBPERIPHERALS = 4,
  parameter int COUNT_WIDTH = 16
);
  logic [7:0] address_in;
  logic address_in_valid;
  logic [7:0] peripheral_data_out;
  logic peripheral_data_out_valid;
  logic [NUM_SUBPERIPHERALS-1:0] subperipheral_enable_out;
  logic [NUM_SUBPERIPHERALS*8-1:0] subperipheral_data_in;
  logic [NUM_SUBPERIPHERALS-1:0] subperipheral_data_in_valid;
  logic [COUNT_WIDTH-1:0] byte_count_out;
  logic unmapped_address_out;
  logic timeout_out;
  modport slave (
    input address_in, address_in_valid, subperipheral_data_in, subperipheral_data_in_valid,
    output peripheral_data_out, peripheral_data_out_valid, subperipheral_enable_out,
    byte_count_out, unmapped_address_out, timeout_out
  );
  modport master (
    output address_in, address_in_valid, subperipheral_data_in, subperipheral_data_in_valid,
    input peripheral_data_out, peripheral_data_out_valid, subperipheral_enable_out,
    byte_count_out, unmapped_address_out, timeout_out
  );
endinterface

// File: rtl/spi_subperipheral_router.sv
// spi_subperipheral_router: latches an SPI address, decodes it to a one-hot channel enable and forwards that channel's strobed bytes (clock_in, reset_in, bus: address/valid in, data/enable/count/unmapped/timeout out)
module spi_subperipheral_router #(
  parameter int NUM_SUBPERIPHERALS = 4,
  parameter logic [NUM_SUBPERIPHERALS*8-1:0] ADDRESS_MAP = {8'hBB, 8'h20, 8'h10, 8'h00},
  parameter int TIMEOUT_CYCLES = 255,
  parameter int COUNT_WIDTH = 16
) (
  input logic clock_in,
  input logic reset_in,
  spi_subperipheral_router_if.slave bus
);
  localparam int SW = NUM_SUBPERIPHERALS > 1 ? $clog2(NUM_SUBPERIPHERALS) : 1;
  localparam int IW = $clog2(TIMEOUT_CYCLES + 2);
  typedef enum logic [2:0] {IDLE, DECODE, ACTIVE, UNMAPPED, TIMEOUT} state_t;
  state_t state, state_n;
  logic [7:0] addr_q;
  logic [SW-1:0] sel_q, hit_idx;
  logic [IW-1:0] idle_cnt;
  logic hit, fwd, expire;
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SUBPERIPHERALS - 1; i >= 0; i--)
      if (ADDRESS_MAP[8*i +: 8] == addr_q) begin
        hit = 1'b1;
        hit_idx = SW'(i);
      end
  end
  always_comb begin
    fwd = state == ACTIVE && bus.address_in_valid && bus.subperipheral_data_in_valid[sel_q];
    expire = TIMEOUT_CYCLES != 0 && !fwd && idle_cnt == IW'(TIMEOUT_CYCLES - 1);
    state_n = !bus.address_in_valid ? IDLE :
              state == IDLE ? DECODE :
              state == DECODE ? (hit ? ACTIVE : UNMAPPED) :
              (state == ACTIVE && expire) ? TIMEOUT : state;
  end
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state <= IDLE;
      addr_q <= '0;
      sel_q <= '0;
      idle_cnt <= '0;
      bus.peripheral_data_out <= '0;
      bus.peripheral_data_out_valid <= 1'b0;
      bus.subperipheral_enable_out <= '0;
      bus.byte_count_out <= '0;
      bus.unmapped_address_out <= 1'b0;
      bus.timeout_out <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.address_in_valid) begin
        addr_q <= bus.address_in;
        bus.byte_count_out <= '0;
      end
      if (state == DECODE) sel_q <= hit_idx;
      idle_cnt <= (state == ACTIVE && !fwd) ? idle_cnt + IW'(1) : '0;
      bus.peripheral_data_out_valid <= fwd;
      if (fwd) bus.peripheral_data_out <= bus.subperipheral_data_in[8*sel_q +: 8];
      if (fwd && !(&bus.byte_count_out)) bus.byte_count_out <= bus.byte_count_out + COUNT_WIDTH'(1);
      bus.subperipheral_enable_out <= state_n != ACTIVE ? '0 :
                                      state == DECODE ? NUM_SUBPERIPHERALS'(1) << hit_idx :
                                      bus.subperipheral_enable_out;
      bus.unmapped_address_out <= state_n == UNMAPPED;
      bus.timeout_out <= state_n == TIMEOUT;
    end
  end
endmodule

// File: tb/tb_spi_subperipheral_router.sv
// tb_spi_subperipheral_router: directed bench with an expected-byte scoreboard for the router
module tb_spi_subperipheral_router;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  always #5 clk = ~clk;
  spi_subperipheral_router_if #(.NUM_SUBPERIPHERALS(4), .COUNT_WIDTH(2)) bus ();
  spi_subperipheral_router #(
    .NUM_SUBPERIPHERALS(4),
    .ADDRESS_MAP({8'hBB, 8'h20, 8'h10, 8'h00}),
    .TIMEOUT_CYCLES(4),
    .COUNT_WIDTH(2)
  ) dut (
    .clock_in(clk),
    .reset_in(rst),
    .bus(bus)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drive(input logic [3:0] v, input logic [31:0] d);
    bus.subperipheral_data_in_valid = v;
    bus.subperipheral_data_in = d;
  endtask
  task automatic txn(input logic [7:0] a, input logic v);
    bus.address_in = a;
    bus.address_in_valid = v;
  endtask
  always @(negedge clk)
    if (bus.peripheral_data_out_valid) begin
      check("sb_nonempty", {31'b0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) check("sb_data", 32'(bus.peripheral_data_out), 32'(exp_q.pop_front()));
    end
  initial begin
    txn(8'h00, 1'b0);
    drive(4'b0, 32'h0);
    step();
    step();
    rst = 1'b0;
    check("rst_en", 32'(bus.subperipheral_enable_out), 32'h0);
    check("rst_dv", 32'(bus.peripheral_data_out_valid), 32'h0);
    check("rst_cnt", 32'(bus.byte_count_out), 32'h0);
    check("rst_flags", {30'b0, bus.unmapped_address_out, bus.timeout_out}, 32'h0);
    txn(8'h20, 1'b1);
    step();
    check("hit_en_edge1", 32'(bus.subperipheral_enable_out), 32'h0);
    step();
    check("hit_en_edge2", 32'(bus.subperipheral_enable_out), 32'h4);
    drive(4'b0100, 32'h00A5_0000);
    exp_q.push_back(8'hA5);
    step();
    check("b2b_dv1", 32'(bus.peripheral_data_out_valid), 32'h1);
    check("b2b_d1", 32'(bus.peripheral_data_out), 32'hA5);
    drive(4'b0100, 32'h005A_0000);
    exp_q.push_back(8'h5A);
    step();
    check("b2b_dv2", 32'(bus.peripheral_data_out_valid), 32'h1);
    check("b2b_d2", 32'(bus.peripheral_data_out), 32'h5A);
    drive(4'b0, 32'h0);
    step();
    check("idle_dv", 32'(bus.peripheral_data_out_valid), 32'h0);
    check("hold_data", 32'(bus.peripheral_data_out), 32'h5A);
    check("cnt_2", 32'(bus.byte_count_out), 32'h2);
    txn(8'h20, 1'b0);
    step();
    check("drop_en", 32'(bus.subperipheral_enable_out), 32'h0);
    check("drop_cnt_hold", 32'(bus.byte_count_out), 32'h2);
    txn(8'h7E, 1'b1);
    step();
    step();
    check("unm_flag", 32'(bus.unmapped_address_out), 32'h1);
    check("unm_en", 32'(bus.subperipheral_enable_out), 32'h0);
    check("unm_cnt_clr", 32'(bus.byte_count_out), 32'h0);
    drive(4'b1111, 32'h1122_3344);
    step();
    check("unm_no_dv", 32'(bus.peripheral_data_out_valid), 32'h0);
    drive(4'b0, 32'h0);
    txn(8'h7E, 1'b0);
    step();
    check("unm_clear", 32'(bus.unmapped_address_out), 32'h0);
    txn(8'h00, 1'b1);
    step();
    step();
    check("to_en", 32'(bus.subperipheral_enable_out), 32'h1);
    step();
    step();
    step();
    check("to_not_yet", 32'(bus.timeout_out), 32'h0);
    check("to_en_held", 32'(bus.subperipheral_enable_out), 32'h1);
    step();
    check("to_flag", 32'(bus.timeout_out), 32'h1);
    check("to_en_off", 32'(bus.subperipheral_enable_out), 32'h0);
    txn(8'h00, 1'b0);
    step();
    check("to_clear", 32'(bus.timeout_out), 32'h0);
    txn(8'hBB, 1'b1);
    step();
    step();
    check("ch3_en", 32'(bus.subperipheral_enable_out), 32'h8);
    bus.address_in = 8'h00;
    drive(4'b1010, 32'h3300_1100);
    exp_q.push_back(8'h33);
    step();
    check("ch3_data", 32'(bus.peripheral_data_out), 32'h33);
    drive(4'b0010, 32'h0000_4400);
    step();
    check("ch1_ignored", 32'(bus.peripheral_data_out_valid), 32'h0);
    check("sel_kept", 32'(bus.subperipheral_enable_out), 32'h8);
    check("ch3_cnt", 32'(bus.byte_count_out), 32'h1);
    drive(4'b1000, 32'h9900_0000);
    bus.address_in_valid = 1'b0;
    step();
    check("drop_strobe_dv", 32'(bus.peripheral_data_out_valid), 32'h0);
    check("drop_strobe_cnt", 32'(bus.byte_count_out), 32'h1);
    check("drop_strobe_data", 32'(bus.peripheral_data_out), 32'h33);
    drive(4'b0, 32'h0);
    txn(8'h10, 1'b1);
    step();
    step();
    check("ch1_en", 32'(bus.subperipheral_enable_out), 32'h2);
    for (int i = 1; i <= 4; i++) begin
      drive(4'b0010, {16'h0, 8'(i), 8'h0});
      exp_q.push_back(8'(i));
      step();
    end
    check("sat_cnt", 32'(bus.byte_count_out), 32'h3);
    drive(4'b0010, 32'h0000_0500);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(4'b0, 32'h0);
    check("mid_rst_en", 32'(bus.subperipheral_enable_out), 32'h0);
    check("mid_rst_dv", 32'(bus.peripheral_data_out_valid), 32'h0);
    check("mid_rst_data", 32'(bus.peripheral_data_out), 32'h0);
    check("mid_rst_cnt", 32'(bus.byte_count_out), 32'h0);
    step();
    step();
    check("restart_en", 32'(bus.subperipheral_enable_out), 32'h2);
    drive(4'b0010, 32'h0000_7700);
    exp_q.push_back(8'h77);
    step();
    drive(4'b0, 32'h0);
    check("restart_data", 32'(bus.peripheral_data_out), 32'h77);
    check("restart_cnt", 32'(bus.byte_count_out), 32'h1);
    txn(8'h10, 1'b0);
    step();
    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
